// File: rtl/control_state_sequencer_pkg.sv
// Shared state, opcode-type and group codes for the control sequencer and signal generation unit.
package control_state_sequencer_pkg;

    localparam int unsigned STATE_COUNT  = 5;
    localparam int unsigned OPCODE_COUNT = 8;
    localparam int unsigned GROUP_COUNT  = 4;

    // One-hot state codes; any other pattern is illegal and recovers to IF.
    typedef enum logic [STATE_COUNT-1:0] {
        STATE_IF  = 5'b00001,
        STATE_ID  = 5'b00010,
        STATE_EX  = 5'b00100,
        STATE_MEM = 5'b01000,
        STATE_WB  = 5'b10000
    } state_e;

    // Bit positions inside the one-hot opcode_type vector.
    typedef enum int unsigned {
        TYPE_NOP      = 0,
        TYPE_ADD      = 1,
        TYPE_LD       = 2,
        TYPE_ST       = 3,
        TYPE_RCALL    = 4,
        TYPE_CALL_ISR = 5,
        TYPE_RET      = 6,
        TYPE_RETI     = 7
    } opcode_type_e;

    // Bit positions inside the opcode_group flag vector.
    typedef enum int unsigned {
        GROUP_ALU    = 0,
        GROUP_MEM    = 1,
        GROUP_STACK  = 2,
        GROUP_BRANCH = 3
    } opcode_group_e;

    // Two-byte stack transfers that need a second MEM cycle; shared with signal generation.
    function automatic logic is_two_mem_cycle(input logic [OPCODE_COUNT-1:0] op_type);
        return op_type[TYPE_RCALL] | op_type[TYPE_CALL_ISR] |
               op_type[TYPE_RET]   | op_type[TYPE_RETI];
    endfunction

endpackage

// File: rtl/control_state_sequencer_irq_boundary_check.sv
// Instruction-boundary predicate: decides whether WB hands over to an injected CALL_ISR.
module control_state_sequencer_irq_boundary_check #(
    parameter bit IRQ_ENABLE = 1'b1
) (
    input  logic in_wb_i,
    input  logic irq_req_i,
    input  logic i_flag_i,
    input  logic is_reti_i,
    input  logic isr_inject_i,
    output logic inject_o
);

    // RETI and the injected call itself must complete before another interrupt is taken.
    assign inject_o = IRQ_ENABLE && in_wb_i && irq_req_i && i_flag_i &&
                      !is_reti_i && !isr_inject_i;

endmodule

// File: rtl/control_state_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer with interrupt injection and debug halt.
module control_state_sequencer
    import control_state_sequencer_pkg::*;
#(
    parameter bit IRQ_ENABLE  = 1'b1,
    parameter bit HALT_ENABLE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_COUNT-1:0] opcode_type,
    input  logic [GROUP_COUNT-1:0]  opcode_group,
    input  logic                    irq_req,
    input  logic                    i_flag,
    input  logic                    halt,
    output logic [STATE_COUNT-1:0]  state,
    output logic                    cycle_count,
    output logic                    isr_inject,
    output logic                    irq_ack,
    output logic                    i_flag_clr,
    output logic                    i_flag_set,
    output logic                    instr_retired,
    output logic                    halted
);

    state_e state_q, state_d;
    logic   cycle_q, cycle_d;
    logic   inject_q, inject_d;
    logic   halted_q, halted_d;
    logic   in_wb;
    logic   two_mem;
    logic   take_irq;
    logic   unused_inputs;

    assign in_wb   = (state_q == STATE_WB);
    // The decoder forces CALL_ISR while injecting; treat it as two-MEM regardless.
    assign two_mem = is_two_mem_cycle(opcode_type) | inject_q;

    control_state_sequencer_irq_boundary_check #(
        .IRQ_ENABLE (IRQ_ENABLE)
    ) u_irq_boundary_check (
        .in_wb_i      (in_wb),
        .irq_req_i    (irq_req),
        .i_flag_i     (i_flag),
        .is_reti_i    (opcode_type[TYPE_RETI]),
        .isr_inject_i (inject_q),
        .inject_o     (take_irq)
    );

    // Next-state logic
    always_comb begin
        state_d  = STATE_IF;
        cycle_d  = 1'b0;
        inject_d = inject_q;
        halted_d = 1'b0;
        case (state_q)
            STATE_IF: begin
                if (HALT_ENABLE && halt) begin
                    state_d  = STATE_IF;
                    halted_d = 1'b1;
                end else begin
                    state_d = STATE_ID;
                end
            end
            STATE_ID: state_d = STATE_EX;
            STATE_EX: state_d = STATE_MEM;
            STATE_MEM: begin
                if (!cycle_q && two_mem) begin
                    state_d = STATE_MEM;
                    cycle_d = 1'b1;
                end else begin
                    state_d = STATE_WB;
                end
            end
            STATE_WB: begin
                // Injection skips IF so the interrupted PC is not advanced.
                if (take_irq) begin
                    state_d  = STATE_ID;
                    inject_d = 1'b1;
                end else begin
                    state_d  = STATE_IF;
                    inject_d = 1'b0;
                end
            end
            default: begin
                state_d  = STATE_IF;
                inject_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= STATE_IF;
            cycle_q  <= 1'b0;
            inject_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycle_q  <= cycle_d;
            inject_q <= inject_d;
            halted_q <= halted_d;
        end
    end

    assign state         = state_q;
    assign cycle_count   = cycle_q;
    assign isr_inject    = inject_q;
    assign halted        = halted_q;

    // WB strobes decode straight off the registered state so each lasts exactly one cycle.
    assign instr_retired = in_wb;
    assign irq_ack       = in_wb & inject_q;
    assign i_flag_clr    = in_wb & opcode_type[TYPE_CALL_ISR];
    assign i_flag_set    = in_wb & opcode_type[TYPE_RETI];

    assign unused_inputs = ^{opcode_group, opcode_type};

endmodule
